// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step pipeline clock-enable controller
//
// A free-running prescaler produces a slow tick. Each tick becomes a one-cycle
// pipeline clock-enable, gated by a HALT/RUN/STEP state machine and a PC breakpoint.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous active-high reset
//   run_req    in   1      pulse: enter free-run
//   halt_req   in   1      pulse: stop (highest priority)
//   step_req   in   1      pulse: advance exactly one pipeline cycle
//   bp_en      in   1      breakpoint enable (level)
//   bp_addr    in   PC_W   breakpoint address
//   pc         in   PC_W   current IF-stage PC
//   cpu_en     out  1      pipeline clock-enable, one clk per advanced cycle
//   state      out  2      00=HALT 01=RUN 10=STEP
//   bp_hit     out  1      sticky: RUN stopped on breakpoint
//   cycle_cnt  out  CYC_W  cpu_en pulses issued since reset (wraps)

module cpu_run_ctrl #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

  logic [15:0]      r_cnt;
  state_t           r_state;
  logic             r_skip;
  logic             r_cpu_en;
  logic             r_bp_hit;
  logic [CYC_W-1:0] r_cycle_cnt;

  logic w_tick;
  logic w_bp_stop;
  logic w_go;
  logic w_pulse;

  assign w_tick    = (r_cnt == CNT_LAST);
  // skip masks the breakpoint for the first tick after entering RUN so that
  // execution can resume from a PC sitting on bp_addr.
  assign w_bp_stop = bp_en & (pc == bp_addr) & ~r_skip;
  assign w_go      = (r_state == ST_STEP) | ((r_state == ST_RUN) & ~w_bp_stop);
  assign w_pulse   = w_tick & w_go & ~halt_req;

  // Prescaler runs in every state; requests never realign it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (w_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HALT;
      r_skip      <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_cpu_en <= w_pulse;
      if (w_pulse) begin
        r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
      end

      if (halt_req) begin
        r_state <= ST_HALT;
      end else begin
        case (r_state)
          ST_HALT: begin
            if (run_req) begin
              r_state  <= ST_RUN;
              r_skip   <= 1'b1;
              r_bp_hit <= 1'b0;
            end else if (step_req) begin
              r_state  <= ST_STEP;
              r_bp_hit <= 1'b0;
            end
          end
          ST_STEP: begin
            // The single pulse is issued on this tick; breakpoint is ignored.
            if (w_tick) begin
              r_state <= ST_HALT;
            end
          end
          ST_RUN: begin
            if (w_tick) begin
              if (w_bp_stop) begin
                r_state  <= ST_HALT;
                r_bp_hit <= 1'b1;
              end else begin
                r_skip <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= ST_HALT;
          end
        endcase
      end
    end
  end

  assign cpu_en    = r_cpu_en;
  assign state     = r_state;
  assign bp_hit    = r_bp_hit;
  assign cycle_cnt = r_cycle_cnt;

endmodule
